// File: rtl/cfg_pkg.sv
// Shared definitions for the CFG construction stage and the dominator-tree
// engine that consumes its predecessor table.
//   OP_*        terminator opcodes carried on the operand stream
//   edge_t      successor edge {src, dst} at the default block-id width
//   bld_state_t build-sequencer states
package cfg_pkg;

    localparam logic [3:0] OP_JMP    = 4'd1;
    localparam logic [3:0] OP_BR     = 4'd2;
    localparam logic [3:0] OP_SWITCH = 4'd3;

    localparam int CFG_BLK_W = 8;

    typedef struct packed {
        logic [CFG_BLK_W-1:0] src;
        logic [CFG_BLK_W-1:0] dst;
    } edge_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCEPT,
        ST_DRAIN
    } bld_state_t;

endpackage

// File: rtl/cfg_target_sel.sv
// Combinational decode of a terminator operand: flags operands that name a
// branch target.
//   op        terminator opcode
//   idx       operand index within the terminator
//   is_target operand is a successor block id
//
// jmp    : operand 0 is the target
// br     : operand 0 is the condition, 1 and 2 are the targets
// switch : operand 0 is the selector, 1 is the default target, then
//          (case value, target) pairs, so targets sit at odd indices >= 3
module cfg_target_sel
    import cfg_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic [3:0]       op,
    input  logic [IDX_W-1:0] idx,
    output logic             is_target
);

    always_comb begin
        is_target = 1'b0;
        case (op)
            OP_JMP:    is_target = (idx == '0);
            OP_BR:     is_target = (idx == IDX_W'(1)) || (idx == IDX_W'(2));
            OP_SWITCH: is_target = (idx == IDX_W'(1)) ||
                                   ((idx >= IDX_W'(3)) && idx[0]);
            default:   is_target = 1'b0;
        endcase
    end

endmodule

// File: rtl/cfg_pred_builder.sv
// CFG construction stage. Consumes per-function terminator operand beats,
// emits successor edges and builds the predecessor table read by the
// dominator engine.
//   clk, rst              clock, synchronous active-high reset
//   start, num_blocks     begin a build of num_blocks blocks (IDLE only)
//   in_*                  operand beat stream (valid/ready)
//   succ_*                successor edge stream (valid/ready, one-entry reg)
//   q_blk, q_slot         predecessor query address
//   q_count, q_pred       registered query result (1-cycle latency)
//   busy, done, overflow  status; done pulses once per completed build
module cfg_pred_builder
    import cfg_pkg::*;
#(
    parameter int BLK_W      = 8,
    parameter int NUM_BLOCKS = 256,
    parameter int MAX_PREDS  = 8,
    parameter int IDX_W      = 8,
    localparam int SLOT_W    = $clog2(MAX_PREDS),
    localparam int CNT_W     = SLOT_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BLK_W:0]    num_blocks,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_blk,
    input  logic [3:0]        in_op,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [BLK_W-1:0]  in_opnd,
    input  logic              in_eof,
    output logic              succ_valid,
    input  logic              succ_ready,
    output logic [BLK_W-1:0]  succ_src,
    output logic [BLK_W-1:0]  succ_dst,
    input  logic [BLK_W-1:0]  q_blk,
    input  logic [SLOT_W-1:0] q_slot,
    output logic [CNT_W-1:0]  q_count,
    output logic [BLK_W-1:0]  q_pred,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    // Same shape as cfg_pkg::edge_t, sized by this instance's BLK_W.
    typedef struct packed {
        logic [BLK_W-1:0] src;
        logic [BLK_W-1:0] dst;
    } blk_edge_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREDS);

    bld_state_t       state, state_nxt;
    logic [BLK_W:0]   nb_q;
    logic [BLK_W-1:0] clr_ptr;
    blk_edge_t        out_q;

    logic [CNT_W-1:0] cnt  [NUM_BLOCKS];
    logic [BLK_W-1:0] pred [NUM_BLOCKS][MAX_PREDS];

    logic             is_tgt;
    logic             out_free;
    logic             load;
    logic             has_room;
    logic             pred_wr;
    logic             clr_last;
    logic [CNT_W-1:0] dst_cnt;

    cfg_target_sel #(.IDX_W(IDX_W)) u_sel (
        .op        (in_op),
        .idx       (in_idx),
        .is_target (is_tgt)
    );

    // The output register can take a new edge when it is empty or is being
    // drained this cycle.
    assign out_free = !succ_valid || succ_ready;
    assign load     = in_valid && in_ready && is_tgt;
    assign dst_cnt  = cnt[in_opnd];
    assign has_room = dst_cnt < CNT_MAX;
    assign pred_wr  = load && has_room;
    assign clr_last = ({1'b0, clr_ptr} == (nb_q - 1'b1));

    assign busy     = (state != ST_IDLE);
    assign succ_src = out_q.src;
    assign succ_dst = out_q.dst;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_last) state_nxt = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                in_ready = out_free;
                if (in_valid && out_free && in_eof) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_free) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Build control, output edge register, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            nb_q       <= '0;
            clr_ptr    <= '0;
            overflow   <= 1'b0;
            succ_valid <= 1'b0;
            out_q      <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                nb_q     <= num_blocks;
                clr_ptr  <= '0;
                overflow <= 1'b0;
            end
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;

            if (load) begin
                succ_valid <= 1'b1;
                out_q      <= '{src: in_blk, dst: in_opnd};
            end else if (succ_ready) begin
                succ_valid <= 1'b0;
            end

            // The edge is still emitted; only the table entry is lost.
            if (load && !has_room) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Predecessor table. CLEAR and edge updates never share a cycle, and
    // only one edge lands per cycle, so a plain increment is safe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BLOCKS; b++) cnt[b] <= '0;
        end else if (state == ST_CLEAR) begin
            cnt[clr_ptr] <= '0;
        end else if (pred_wr) begin
            cnt[in_opnd] <= dst_cnt + CNT_W'(1);
        end
    end

    // Slots are not cleared; entries at or above count are stale by design.
    always_ff @(posedge clk) begin
        if (pred_wr) pred[in_opnd][dst_cnt[SLOT_W-1:0]] <= in_blk;
    end

    // ------------------------------------------------------------------
    // Query port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_count <= '0;
            q_pred  <= '0;
        end else begin
            q_count <= cnt[q_blk];
            q_pred  <= pred[q_blk][q_slot];
        end
    end

endmodule

// File: tb/tb_cfg_pred_builder.sv
module tb_cfg_pred_builder;
    import cfg_pkg::*;

    localparam int NB = 256;
    localparam int MP = 8;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [8:0] num_blocks;
    logic       in_valid, in_ready;
    logic [7:0] in_blk, in_idx, in_opnd;
    logic [3:0] in_op;
    logic       in_eof;
    logic       succ_valid, succ_ready;
    logic [7:0] succ_src, succ_dst;
    logic [7:0] q_blk;
    logic [2:0] q_slot;
    logic [3:0] q_count;
    logic [7:0] q_pred;
    logic       busy, done, overflow;

    cfg_pred_builder dut (
        .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
        .in_valid(in_valid), .in_ready(in_ready), .in_blk(in_blk),
        .in_op(in_op), .in_idx(in_idx), .in_opnd(in_opnd), .in_eof(in_eof),
        .succ_valid(succ_valid), .succ_ready(succ_ready),
        .succ_src(succ_src), .succ_dst(succ_dst),
        .q_blk(q_blk), .q_slot(q_slot), .q_count(q_count), .q_pred(q_pred),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         vecs = 0;
    int         errs = 0;
    int         done_cnt = 0;
    logic [15:0] exp_q[$];
    int         exp_cnt [NB];
    logic [7:0] exp_pred [NB][MP];
    bit         exp_ovf;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Edge monitor: a transfer happens at the next posedge when both are high.
    always @(negedge clk) begin
        if (!rst && succ_valid && succ_ready) begin
            if (exp_q.size() == 0) chk("unexpected_edge", {succ_src, succ_dst}, 32'hFFFF_FFFF);
            else chk("edge", {succ_src, succ_dst}, exp_q.pop_front());
        end
        if (done) done_cnt++;
    end

    task automatic do_start(input int n);
        int t;
        start = 1'b1;
        num_blocks = 9'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < n; b++) exp_cnt[b] = 0;
        exp_ovf = 1'b0;
        chk("busy_start", busy, 1);
        t = 0;
        while (!in_ready && t < n + 10) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_latency", t, n);
    endtask

    task automatic send(input int blk, input int op, input int idx, input int opnd,
                        input bit eof, input bit tgt);
        int t;
        in_valid = 1'b1;
        in_blk   = 8'(blk);
        in_op    = 4'(op);
        in_idx   = 8'(idx);
        in_opnd  = 8'(opnd);
        in_eof   = eof;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_seen", in_ready, 1);
        if (tgt) begin
            exp_q.push_back({8'(blk), 8'(opnd)});
            if (exp_cnt[opnd] < MP) begin
                exp_pred[opnd][exp_cnt[opnd]] = 8'(blk);
                exp_cnt[opnd]++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
        chk("idle_after_done", busy, 0);
    endtask

    task automatic chk_q(input int b, input int s);
        q_blk  = 8'(b);
        q_slot = 3'(s);
        @(posedge clk); #1;
        chk("q_count", q_count, exp_cnt[b]);
        if (s < exp_cnt[b]) chk("q_pred", q_pred, exp_pred[b][s]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; num_blocks = '0;
        in_valid = 1'b0; in_blk = '0; in_op = '0; in_idx = '0; in_opnd = '0; in_eof = 1'b0;
        succ_ready = 1'b1; q_blk = '0; q_slot = '0;
        for (int b = 0; b < NB; b++) exp_cnt[b] = 0;
        exp_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 0);
        chk("rst_succ", {succ_valid, succ_src, succ_dst}, 0);
        chk("rst_status", {busy, done, overflow}, 0);
        chk("rst_q", {q_count, q_pred}, 0);

        // jmp: single eof target, done one cycle after acceptance
        do_start(4);
        send(0, OP_JMP, 0, 2, 1'b1, 1'b1);
        chk("jmp_done_1cyc", done, 1);
        @(posedge clk); #1;
        chk("jmp_done_pulse", {done, busy}, 0);
        chk_q(2, 0);
        chk_q(1, 0);
        chk("jmp_sb_empty", exp_q.size(), 0);

        // br: idx0 is the condition, no edge
        do_start(4);
        send(1, OP_BR, 0, 7, 1'b0, 1'b0);
        send(1, OP_BR, 1, 2, 1'b0, 1'b1);
        send(1, OP_BR, 2, 3, 1'b1, 1'b1);
        wait_done();
        chk_q(2, 0);
        chk_q(3, 0);
        chk("br_sb_empty", exp_q.size(), 0);

        // switch: targets at idx 1,3,5
        do_start(4);
        send(3, OP_SWITCH, 0, 9, 1'b0, 1'b0);
        send(3, OP_SWITCH, 1, 1, 1'b0, 1'b1);
        send(3, OP_SWITCH, 2, 9, 1'b0, 1'b0);
        send(3, OP_SWITCH, 3, 2, 1'b0, 1'b1);
        send(3, OP_SWITCH, 4, 9, 1'b0, 1'b0);
        send(3, OP_SWITCH, 5, 0, 1'b0, 1'b1);
        send(3, OP_SWITCH, 6, 9, 1'b1, 1'b0);
        wait_done();
        chk_q(0, 0);
        chk_q(1, 0);
        chk_q(2, 0);
        // Non-terminator opcode is ignored
        do_start(4);
        send(0, 5, 0, 1, 1'b0, 1'b0);
        send(0, OP_JMP, 0, 1, 1'b1, 1'b1);
        wait_done();
        chk_q(1, 0);
        chk("sw_sb_empty", exp_q.size(), 0);

        // Overflow: 10 predecessors into block 5
        do_start(16);
        chk("ovf_clear", overflow, 0);
        for (int i = 0; i < 10; i++) send(6 + i, OP_JMP, 0, 5, (i == 9), 1'b1);
        wait_done();
        chk("ovf_set", overflow, exp_ovf);
        for (int s = 0; s < MP; s++) chk_q(5, s);
        chk("ovf_sb_empty", exp_q.size(), 0);

        // Backpressure on the first edge
        do_start(8);
        chk("ovf_cleared_by_start", overflow, 0);
        succ_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(i, OP_JMP, 0, 4 + i, (i == 3), 1'b1);
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!succ_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_valid", succ_valid, 1);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold", {succ_src, succ_dst}, 16'h0004);
                    @(negedge clk);
                end
                @(posedge clk); #2;
                succ_ready = 1'b1;
            end
        join
        wait_done();
        for (int b = 4; b < 8; b++) chk_q(b, 0);
        chk("bp_sb_empty", exp_q.size(), 0);

        // Reset mid-ACCEPT, then rebuild
        do_start(8);
        send(0, OP_JMP, 0, 3, 1'b0, 1'b1);
        send(1, OP_JMP, 0, 4, 1'b0, 1'b1);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        for (int b = 0; b < NB; b++) exp_cnt[b] = 0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_succ", succ_valid, 0);
        @(posedge clk); #1;
        chk("rst_mid_no_done", done_cnt, d0);
        chk_q(3, 0);
        chk_q(4, 0);
        chk_q(2, 0);

        do_start(2);
        send(0, OP_JMP, 0, 1, 1'b0, 1'b1);
        send(1, OP_BR, 1, 0, 1'b0, 1'b1);
        send(1, OP_BR, 2, 1, 1'b1, 1'b1);
        wait_done();
        chk_q(0, 0);
        chk_q(1, 0);
        chk_q(1, 1);
        chk("rebuild_ovf", overflow, 0);
        chk("rebuild_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cfg_pred_builder.md
# cfg_pred_builder

Hardware CFG construction stage. It sits directly upstream of the dominator-tree engine in the SSA optimisation pipeline. It consumes a per-function stream of terminator operands, selects the operands that are branch targets according to the terminator opcode, and emits successor edges on an output stream. It also builds the predecessor table that the dominator engine reads through a registered query port.

## Interface
Parameters:
- BLK_W, 8, block-id width
- NUM_BLOCKS, 256, predecessor-table depth; must equal 2**BLK_W
- MAX_PREDS, 8, predecessor slots per block
- IDX_W, 8, operand-index width

Ports (one clock; reset is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a function; sampled only in IDLE
- num_blocks  in  BLK_W+1  number of blocks in the function (1..NUM_BLOCKS); captured on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_blk  in  BLK_W  source block id
- in_op  in  4  terminator opcode (pkg constants)
- in_idx  in  IDX_W  operand index within the terminator
- in_opnd  in  BLK_W  operand value, interpreted as a block id
- in_eof  in  1  last beat of the function
- succ_valid  out  1  successor edge valid
- succ_ready  in  1  downstream accept
- succ_src  out  BLK_W  edge source block
- succ_dst  out  BLK_W  edge destination block
- q_blk  in  BLK_W  predecessor query block
- q_slot  in  $clog2(MAX_PREDS)  predecessor query slot
- q_count  out  $clog2(MAX_PREDS)+1  registered predecessor count of q_blk
- q_pred  out  BLK_W  registered predecessor at [q_blk][q_slot]
- busy  out  1  high in CLEAR, ACCEPT and DRAIN
- done  out  1  one-cycle pulse at end of build
- overflow  out  1  sticky; a predecessor was dropped

## Operation
- States: IDLE, CLEAR, ACCEPT, DRAIN.
- IDLE:
  - in_ready=0.
  - start=1 goes to CLEAR, sets clr_ptr=0 and clears overflow.
  - start in any other state is ignored.
- CLEAR:
  - Zeroes count[clr_ptr], one block per cycle.
  - Goes to ACCEPT after clr_ptr==num_blocks-1, i.e. num_blocks cycles.
- ACCEPT:
  - in_ready = !succ_valid || succ_ready (single-entry output register).
  - A beat is a target when one of these holds:
    - in_op==OP_JMP && idx==0
    - in_op==OP_BR && idx∈{1,2}
    - in_op==OP_SWITCH && (idx==1 || (idx>=3 && idx odd))
  - All other beats, including non-terminator opcodes, are consumed without effect.
  - On an accepted target beat:
    - Load the output register with src=in_blk, dst=in_opnd.
    - If count[dst]<MAX_PREDS: write pred[dst][count[dst]]=in_blk and increment count[dst].
    - Otherwise drop the predecessor entry, set overflow, and still emit the edge.
  - Duplicate edges are not merged. A br with both targets equal yields two predecessor entries.
  - An accepted beat with in_eof goes to DRAIN.
- DRAIN:
  - in_ready=0.
  - When the output register is empty, or empties this cycle, pulse done and go to IDLE.
- Query port:
  - q_count and q_pred are registered from q_blk/q_slot with 1-cycle latency, in every state.
  - During a build the port returns in-progress contents.
  - A slot >= count returns stale data.
- Counts are held in flops; there is at most one edge per cycle, so there is no read-modify-write hazard.

## Timing
- Reset values: in_ready=0, succ_valid=0, succ_src=0, succ_dst=0, q_count=0, q_pred=0, busy=0, done=0, overflow=0, state=IDLE, all counts=0.
- rst mid-build aborts to IDLE on the next edge. The current edge is discarded; no done pulse.
- start to first in_ready: 1+num_blocks cycles.
- Target beat to succ_valid: 1 cycle. Predecessor-table update is visible on q_* 2 cycles after acceptance.
- Throughput is 1 beat/cycle while succ_ready=1.
- succ_src and succ_dst are held stable while succ_valid && !succ_ready.
- Acceptance of the eof beat to done: 1 cycle when the eof beat is a target and succ_ready=1; otherwise the drain wait plus 1.

## Structure
- cfg_pkg holds:
  - the opcode constants OP_JMP=1, OP_BR=2, OP_SWITCH=3;
  - the edge_t typedef {src, dst}.
- The dominator engine imports the same package.
- One sub-module, cfg_target_sel: combinational decode of (op, idx) into an is_target flag.
- Predecessor storage is a flop array, NUM_BLOCKS×MAX_PREDS×BLK_W, instantiated in cfg_pred_builder itself.

## Test plan
- **jmp:** start with num_blocks=4. Send beat blk0/jmp/idx0/opnd2/eof, succ_ready=1. Expect edge (0,2), q_count[2]=1, q_pred[2][0]=0, done 1 cycle after the beat.
- **br:** send br beats for blk1, idx 0..2 with opnd {7,2,3}. Expect edges (1,2),(1,3) only; count[2] and count[3] each increment by 1; the idx0 beat produces no edge.
- **switch:** send blk3, idx 0..6, opnd {9,1,9,2,9,0,9}. Expect edges (3,1),(3,2),(3,0), in that order.
- **Overflow:** MAX_PREDS=8; send 10 jmp edges to block 5 from distinct sources. Expect q_count[5]=8, slots holding the first 8 sources, overflow=1, all 10 edges emitted.
- **Backpressure:** hold succ_ready=0 for 5 cycles on the first edge. Expect in_ready=0 and succ_* stable; after release, every later edge appears in order with none lost.
- **Reset and rebuild:**
  - Assert rst in the middle of ACCEPT. Expect busy=0, no done pulse, all q_count=0.
  - A new start with num_blocks=2 then builds cleanly.
